dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder to the pipelined datapath's memory stage.
- Accepts the M-stage load/store request: byte address from aluoutM, data from writedataM.
- Serves the request from an internal word RAM with configurable latency and returns load data on readdataM.
- Raises memstall so the hazard unit freezes the pipeline while an access is outstanding.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the RAM; addressable range is 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2, wait cycles between acceptance and access; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- memreadM  input  1  load request from the M stage.
- memwriteM  input  1  store request from the M stage.
- aluoutM  input  32  byte address.
- writedataM  input  32  store data.
- readdataM  output  32  load data, registered.
- memstall  output  1  pipeline freeze request to the hazard unit.
- memerr  output  1  one-cycle pulse: misaligned, out-of-range or conflicting request.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, counter 0, readdataM=32'h0, memstall=0, memerr=0. RAM contents are not reset. A pending access is dropped; a pending store never commits.
- req = memreadM | memwriteM.
- bad = (aluoutM[1:0] != 0) | (aluoutM[31:2] >= DEPTH_WORDS).
- States: IDLE, BUSY, DONE.
- IDLE, req & !bad:
  - Capture word index aluoutM[31:2], writedataM and op.
  - op = store if memwriteM, else load.
  - Load counter with LATENCY-1 and go to BUSY.
  - memstall=1 combinationally in this same cycle.
- IDLE, req & bad:
  - No access, no stall, no state change.
  - memerr=1 in that cycle (combinational).
  - readdataM unchanged.
- IDLE, !req: stay in IDLE, memstall=0.
- BUSY:
  - memstall=1. Inputs are ignored; captured values are used.
  - Counter decrements each cycle.
  - When counter==0: a store writes the RAM word, a load registers the RAM word into readdataM. Go to DONE.
- DONE:
  - memstall=0 so the pipeline advances this cycle.
  - readdataM holds the load result.
  - The request still visible on the inputs is the completed one and is ignored.
  - Go to IDLE next cycle.
- Timing: a request accepted in cycle t has memstall high for cycles t..t+LATENCY. memstall is low and readdataM valid at t+LATENCY+1. Back-to-back requests therefore cost LATENCY+2 cycles each.
- Store: readdataM is unchanged by stores.
- memreadM & memwriteM together:
  - Treated as a store.
  - memerr pulses in the acceptance cycle.
  - The access still proceeds.
- Read-after-write to the same word on consecutive requests returns the new data.
- readdataM holds its last load value indefinitely between loads.
- Counter width is 4 bits; no wrap occurs within the legal LATENCY range.

Decomposition:
- Package dmem_pkg: state enum (IDLE, BUSY, DONE), WORD_BYTES=4, LAT_W=4.
- Sub-module ram_sp: single-port synchronous word RAM.
  - Parameter DEPTH.
  - Ports: clk, we, addr, wd, rd. Read data is registered.
  - No reset.
- The FSM, address check and counter stay in dmem_responder.

Test Plan:
1. Reset mid-BUSY: assert reset=0 during a store to 0x10 → state IDLE, memstall=0, readdataM=0 immediately. A later load of 0x10 returns the old contents.
2. Store then load:
   - Store 0xDEADBEEF to 0x8 with LATENCY=2 → memstall high 3 cycles, then low 1 cycle.
   - Load from 0x8 → readdataM=0xDEADBEEF exactly 3 cycles after acceptance, held afterwards.
3. Misaligned load at 0x6 → memerr=1 same cycle, memstall=0, readdataM unchanged, RAM untouched.
4. Out-of-range address 0x100 with DEPTH_WORDS=64 → memerr=1, no stall. The boundary address 0xFC is accepted normally.
5. Conflicting request: memreadM=memwriteM=1 at 0x4 with data 0x1234 → memerr pulse, store completes, a subsequent load of 0x4 returns 0x1234.
6. Latency sweep: LATENCY=1 gives 2 stall cycles, LATENCY=15 gives 16 stall cycles. Holding a request unchanged through DONE does not retrigger an access in that cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the memory-stage responder.
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LAT_W      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } stateT;

  typedef enum logic {
    OpLoad,
    OpStore
  } opT;

  // A request is unusable when not word aligned or beyond the last RAM word.
  function automatic logic addrBad(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage load/store request bus between the datapath and the data memory.
interface dmem_responder_if;

  logic        memreadM;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        memstall;
  logic        memerr;

  modport master (
    output memreadM,
    output memwriteM,
    output aluoutM,
    output writedataM,
    input  readdataM,
    input  memstall,
    input  memerr
  );

  modport slave (
    input  memreadM,
    input  memwriteM,
    input  aluoutM,
    input  writedataM,
    output readdataM,
    output memstall,
    output memerr
  );

endinterface

// File: rtl/ram_sp.sv
// Single-port synchronous word RAM with registered read data; contents are not reset.
module ram_sp #(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wd;
    end
    rd <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: serves one load/store at a time from a word RAM after a
// fixed latency and stalls the pipeline while the access is outstanding.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  stateT             stateQ, stateD;
  logic [LAT_W-1:0]  cntQ;
  logic [AW-1:0]     addrQ;
  logic [31:0]       dataQ;
  opT                opQ;
  logic [31:0]       readdataQ;

  logic              req;
  logic              bad;
  logic              accept;
  logic              fire;
  logic [AW-1:0]     aluIdx;
  logic [AW-1:0]     ramAddr;
  logic              ramWe;
  logic [31:0]       ramRd;

  assign req    = bus.memreadM | bus.memwriteM;
  assign bad    = addrBad(bus.aluoutM, DEPTH_WORDS);
  assign accept = (stateQ == StIdle) && req && !bad;
  assign fire   = (stateQ == StBusy) && (cntQ == '0);
  assign aluIdx = bus.aluoutM[AW+1:2];

  // Present the live address while idle so the registered read is ready by the
  // final busy cycle even when LATENCY is 1.
  assign ramAddr = (stateQ == StIdle) ? (bad ? '0 : aluIdx) : addrQ;
  assign ramWe   = fire && (opQ == OpStore);

  ram_sp #(
    .DEPTH(DEPTH_WORDS)
  ) uRam (
    .clk (clk),
    .we  (ramWe),
    .addr(ramAddr),
    .wd  (dataQ),
    .rd  (ramRd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (accept) stateD = StBusy;
      StBusy:  if (fire) stateD = StDone;
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    bus.memstall = 1'b0;
    bus.memerr   = 1'b0;
    unique case (stateQ)
      StIdle: begin
        bus.memstall = accept;
        bus.memerr   = req && (bad || (bus.memreadM && bus.memwriteM));
      end
      StBusy:  bus.memstall = 1'b1;
      StDone:  bus.memstall = 1'b0;
      default: bus.memstall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cntQ      <= '0;
      addrQ     <= '0;
      dataQ     <= '0;
      opQ       <= OpLoad;
      readdataQ <= '0;
    end else begin
      if (accept) begin
        cntQ  <= LAT_W'(LATENCY - 1);
        addrQ <= aluIdx;
        dataQ <= bus.writedataM;
        opQ   <= bus.memwriteM ? OpStore : OpLoad;
      end else if ((stateQ == StBusy) && (cntQ != '0)) begin
        cntQ <= cntQ - 1'b1;
      end
      if (fire && (opQ == OpLoad)) begin
        readdataQ <= ramRd;
      end
    end
  end

  assign bus.readdataM = readdataQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance plus LATENCY=1/15 for the sweep.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        memreadM;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;

  int nVec  = 0;
  int nMiss = 0;

  dmem_responder_if bus1 ();
  dmem_responder_if bus2 ();
  dmem_responder_if bus15 ();

  assign bus1.memreadM    = memreadM;
  assign bus1.memwriteM   = memwriteM;
  assign bus1.aluoutM     = aluoutM;
  assign bus1.writedataM  = writedataM;
  assign bus2.memreadM    = memreadM;
  assign bus2.memwriteM   = memwriteM;
  assign bus2.aluoutM     = aluoutM;
  assign bus2.writedataM  = writedataM;
  assign bus15.memreadM   = memreadM;
  assign bus15.memwriteM  = memwriteM;
  assign bus15.aluoutM    = aluoutM;
  assign bus15.writedataM = writedataM;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1));
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2))  dut2  (.clk(clk), .reset(reset), .bus(bus2));
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(15)) dut15 (.clk(clk), .reset(reset), .bus(bus15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one request on the LATENCY=2 instance; returns in its first non-stall cycle.
  task automatic runReq(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output int stalls, output logic err);
    @(negedge clk);
    memreadM   = rd;
    memwriteM  = wr;
    aluoutM    = addr;
    writedataM = wd;
    #1;
    err    = bus2.memerr;
    stalls = 0;
    while (bus2.memstall && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    memreadM  = 1'b0;
    memwriteM = 1'b0;
  endtask

  initial begin
    int   st;
    logic er;
    int   run1, run2, run15;
    logic done1, done2, done15;
    logic doneStall;

    reset      = 1'b0;
    memreadM   = 1'b0;
    memwriteM  = 1'b0;
    aluoutM    = '0;
    writedataM = '0;
    doneStall  = 1'b1;
    repeat (2) @(negedge clk);
    checkVal("resetRd", bus2.readdataM, 32'h0);
    checkVal("resetStall", {31'b0, bus2.memstall}, 32'h0);
    checkVal("resetErr", {31'b0, bus2.memerr}, 32'h0);
    reset = 1'b1;

    // Store then load, LATENCY=2.
    runReq(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, st, er);
    checkVal("storeStalls", st, 3);
    checkVal("storeErr", {31'b0, er}, 32'h0);
    runReq(1'b1, 1'b0, 32'h8, 32'h0, st, er);
    checkVal("loadStalls", st, 3);
    checkVal("loadData", bus2.readdataM, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    #1;
    checkVal("loadHeld", bus2.readdataM, 32'hDEADBEEF);

    // Misaligned load.
    runReq(1'b1, 1'b0, 32'h6, 32'h0, st, er);
    checkVal("misalErr", {31'b0, er}, 32'h1);
    checkVal("misalStalls", st, 0);
    checkVal("misalRd", bus2.readdataM, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    checkVal("errPulse", {31'b0, bus2.memerr}, 32'h0);

    // Out of range, then the last legal word.
    runReq(1'b1, 1'b0, 32'h100, 32'h0, st, er);
    checkVal("oorErr", {31'b0, er}, 32'h1);
    checkVal("oorStalls", st, 0);
    runReq(1'b0, 1'b1, 32'hFC, 32'hCAFEF00D, st, er);
    checkVal("edgeStStalls", st, 3);
    checkVal("edgeStErr", {31'b0, er}, 32'h0);
    checkVal("storeKeepsRd", bus2.readdataM, 32'hDEADBEEF);
    runReq(1'b1, 1'b0, 32'hFC, 32'h0, st, er);
    checkVal("edgeLoad", bus2.readdataM, 32'hCAFEF00D);

    // Read and write together: treated as a store with an error pulse.
    runReq(1'b1, 1'b1, 32'h4, 32'h1234, st, er);
    checkVal("conflErr", {31'b0, er}, 32'h1);
    checkVal("conflStalls", st, 3);
    runReq(1'b1, 1'b0, 32'h4, 32'h0, st, er);
    checkVal("conflLoad", bus2.readdataM, 32'h1234);

    // Misaligned 0x6 must not have disturbed word 1 or word 2.
    runReq(1'b1, 1'b0, 32'h8, 32'h0, st, er);
    checkVal("ramUntouched", bus2.readdataM, 32'hDEADBEEF);

    // Reset in the middle of a store: the store is dropped.
    runReq(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, st, er);
    runReq(1'b1, 1'b0, 32'h4, 32'h0, st, er);
    @(negedge clk);
    memwriteM  = 1'b1;
    aluoutM    = 32'h10;
    writedataM = 32'h11111111;
    @(negedge clk);
    reset     = 1'b0;
    memwriteM = 1'b0;
    #1;
    checkVal("midRstStall", {31'b0, bus2.memstall}, 32'h0);
    checkVal("midRstRd", bus2.readdataM, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    runReq(1'b1, 1'b0, 32'h10, 32'h0, st, er);
    checkVal("postRstStalls", st, 3);
    checkVal("postRstLoad", bus2.readdataM, 32'hA5A5A5A5);

    // Latency sweep with the request held across completion.
    reset = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    run1   = 0;
    run2   = 0;
    run15  = 0;
    done1  = 1'b0;
    done2  = 1'b0;
    done15 = 1'b0;
    @(negedge clk);
    memreadM = 1'b1;
    aluoutM  = 32'h8;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!done1)  begin if (bus1.memstall)  run1++;  else done1  = 1'b1; end
      if (!done2)  begin if (bus2.memstall)  run2++;  else done2  = 1'b1; end
      if (!done15) begin if (bus15.memstall) run15++; else done15 = 1'b1; end
      if (i == 2) doneStall = bus1.memstall;
      @(negedge clk);
    end
    memreadM = 1'b0;
    checkVal("lat1Stalls", run1, 2);
    checkVal("lat2Stalls", run2, 3);
    checkVal("lat15Stalls", run15, 16);
    checkVal("doneNoRetrig", {31'b0, doneStall}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
